// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and default geometry for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned FwdRf        = 0;
  localparam int unsigned DefNreg      = 32;
  localparam int unsigned DefRw        = 5;
  localparam int unsigned DefNstage    = 3;
  localparam int unsigned DefLoadStage = 2;
  localparam int unsigned DefBrStage   = 2;
  localparam int unsigned DefCntw      = 32;

  function automatic int unsigned sel_width(input int unsigned nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/hazard_src_check.sv
// Per-operand RAW check: finds the youngest in-flight producer of one source
// register and decides between stall, forward, or plain regfile read.
module hazard_src_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned RW         = DefRw,
  parameter int unsigned NSTAGE     = DefNstage,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned WB_BYPASS  = 1,
  parameter int unsigned LOAD_STAGE = DefLoadStage,
  parameter int unsigned SW         = sel_width(NSTAGE)
) (
  input  logic [NSTAGE-1:0]         v_i,
  input  logic [NSTAGE-1:0][RW-1:0] rd_i,
  input  logic [NSTAGE-1:0]         ld_i,
  input  logic [RW-1:0]             src_i,
  input  logic                      use_i,
  output logic                      match_o,
  output logic [SW-1:0]             m_o,
  output logic                      hazard_o,
  output logic [SW-1:0]             fwd_o
);

  int unsigned mi;
  logic        ldm;
  logic        active;

  always_comb begin
    mi  = 0;
    ldm = 1'b0;
    // Scan oldest to youngest so the youngest producer is the one left standing.
    for (int unsigned s = NSTAGE; s >= 1; s--) begin
      if (v_i[s-1] && (rd_i[s-1] == src_i)) begin
        mi  = s;
        ldm = ld_i[s-1];
      end
    end

    active  = use_i && (src_i != '0);
    match_o = active && (mi != 0);
    m_o     = SW'(mi);

    if (FWD_EN != 0) begin
      hazard_o = match_o && ldm && (mi < LOAD_STAGE);
    end else begin
      hazard_o = match_o && ((mi < NSTAGE) || (WB_BYPASS == 0));
    end

    fwd_o = SW'(FwdRf);
    if ((FWD_EN != 0) && match_o && !hazard_o && !((mi == NSTAGE) && (WB_BYPASS != 0))) begin
      fwd_o = SW'(mi);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard interlock/forwarding controller: tracks in-flight destinations per
// stage, stalls ID on unresolvable RAW hazards and squashes wrong-path entries.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG       = DefNreg,
  parameter int unsigned RW         = $clog2(NREG),
  parameter int unsigned NSTAGE     = DefNstage,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned WB_BYPASS  = 1,
  parameter int unsigned LOAD_STAGE = DefLoadStage,
  parameter int unsigned BR_STAGE   = DefBrStage,
  parameter int unsigned CNTW       = DefCntw
) (
  input  logic                            clk1,
  input  logic                            reset,
  input  logic                            id_valid,
  input  logic [RW-1:0]                   id_rs,
  input  logic [RW-1:0]                   id_rt,
  input  logic                            id_use_rs,
  input  logic                            id_use_rt,
  input  logic [RW-1:0]                   id_rd,
  input  logic                            id_wr,
  input  logic                            id_load,
  input  logic                            flush,
  input  logic                            halted,
  output logic                            stall,
  output logic                            issue,
  output logic [sel_width(NSTAGE)-1:0]    fwd_a,
  output logic [sel_width(NSTAGE)-1:0]    fwd_b,
  output logic [CNTW-1:0]                 stall_count
);

  localparam int unsigned SW = sel_width(NSTAGE);

  logic [NSTAGE-1:0]         v_q, v_d;
  logic [NSTAGE-1:0]         ld_q, ld_d;
  logic [NSTAGE-1:0][RW-1:0] rd_q, rd_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;

  logic          match_a, match_b, haz_a, haz_b;
  logic [SW-1:0] m_a, m_b;
  logic          unused_m;

  assign unused_m = ^{match_a, match_b, m_a, m_b};

  hazard_src_check #(
    .RW         (RW),
    .NSTAGE     (NSTAGE),
    .FWD_EN     (FWD_EN),
    .WB_BYPASS  (WB_BYPASS),
    .LOAD_STAGE (LOAD_STAGE),
    .SW         (SW)
  ) u_chk_a (
    .v_i      (v_q),
    .rd_i     (rd_q),
    .ld_i     (ld_q),
    .src_i    (id_rs),
    .use_i    (id_use_rs),
    .match_o  (match_a),
    .m_o      (m_a),
    .hazard_o (haz_a),
    .fwd_o    (fwd_a)
  );

  hazard_src_check #(
    .RW         (RW),
    .NSTAGE     (NSTAGE),
    .FWD_EN     (FWD_EN),
    .WB_BYPASS  (WB_BYPASS),
    .LOAD_STAGE (LOAD_STAGE),
    .SW         (SW)
  ) u_chk_b (
    .v_i      (v_q),
    .rd_i     (rd_q),
    .ld_i     (ld_q),
    .src_i    (id_rt),
    .use_i    (id_use_rt),
    .match_o  (match_b),
    .m_o      (m_b),
    .hazard_o (haz_b),
    .fwd_o    (fwd_b)
  );

  // A flush outranks any stall condition; halted drains without issuing.
  assign stall       = id_valid && !halted && !flush && (haz_a || haz_b);
  assign issue       = id_valid && !halted && !flush && !stall;
  assign stall_count = cnt_q;

  always_comb begin
    v_d  = '0;
    ld_d = '0;
    rd_d = '0;

    v_d[0]  = issue && id_wr && (id_rd != '0);
    ld_d[0] = issue && id_load;
    rd_d[0] = issue ? id_rd : '0;

    // Entry leaving stage i moves to i+1; younger-than-branch entries die on flush.
    for (int unsigned i = 1; i < NSTAGE; i++) begin
      v_d[i]  = v_q[i-1] && !(flush && (i < BR_STAGE));
      ld_d[i] = ld_q[i-1];
      rd_d[i] = rd_q[i-1];
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      v_q   <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding and an interlock-only
// instance share one instruction stream and are checked against a stage model.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_wr = 1'b0, id_load = 1'b0;
  logic       flush = 1'b0, halted = 1'b0;

  logic        stall_f, issue_f, stall_i, issue_i;
  logic [1:0]  fa_f, fb_f, fa_i, fb_i;
  logic [31:0] cnt_f, cnt_i;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: index 0 = forwarding instance, 1 = interlock-only; stages 1..3.
  bit mv [2][1:3];
  int mrd[2][1:3];
  bit mld[2][1:3];
  int mcnt[2];

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(1)) u_fwd (
    .clk1 (clk), .reset (reset), .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt), .id_rd (id_rd), .id_wr (id_wr),
    .id_load (id_load), .flush (flush), .halted (halted), .stall (stall_f),
    .issue (issue_f), .fwd_a (fa_f), .fwd_b (fb_f), .stall_count (cnt_f)
  );

  hazard_scoreboard #(.FWD_EN(0)) u_ilk (
    .clk1 (clk), .reset (reset), .id_valid (id_valid), .id_rs (id_rs), .id_rt (id_rt),
    .id_use_rs (id_use_rs), .id_use_rt (id_use_rt), .id_rd (id_rd), .id_wr (id_wr),
    .id_load (id_load), .flush (flush), .halted (halted), .stall (stall_i),
    .issue (issue_i), .fwd_a (fa_i), .fwd_b (fb_i), .stall_count (cnt_i)
  );

  function automatic void opnd(input int c, input bit use_, input int src,
                               output bit hz, output int fw);
    int m = 0;
    for (int s = 1; s <= 3; s++) if (m == 0 && mv[c][s] && mrd[c][s] == src) m = s;
    if (!use_ || src == 0) m = 0;
    if (c == 0) begin
      hz = (m != 0) && mld[c][m] && (m < 2);
      fw = (m != 0 && !hz && m != 3) ? m : 0;
    end else begin
      hz = (m != 0) && (m < 3);
      fw = 0;
    end
  endfunction

  function automatic void model_eval(input int c, output bit st, output bit is,
                                     output int fa, output int fb);
    bit ha, hb, go;
    opnd(c, id_use_rs, int'(id_rs), ha, fa);
    opnd(c, id_use_rt, int'(id_rt), hb, fb);
    go = id_valid && !halted && !flush;
    st = go && (ha || hb);
    is = go && !st;
  endfunction

  task automatic model_update();
    bit st, is;
    int fa, fb;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        for (int s = 1; s <= 3; s++) begin mv[c][s] = 0; mrd[c][s] = 0; mld[c][s] = 0; end
        mcnt[c] = 0;
      end else begin
        model_eval(c, st, is, fa, fb);
        for (int s = 3; s >= 2; s--) begin
          mv[c][s]  = mv[c][s-1] && !(flush && (s - 1) < 2);
          mrd[c][s] = mrd[c][s-1];
          mld[c][s] = mld[c][s-1];
        end
        mv[c][1]  = is && id_wr && (id_rd != 0);
        mrd[c][1] = is ? int'(id_rd) : 0;
        mld[c][1] = is && id_load;
        if (st) mcnt[c]++;
      end
    end
  endtask

  task automatic cmp(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    bit st, is;
    int fa, fb;
    if (chk_en) begin
      model_eval(0, st, is, fa, fb);
      cmp("m_stall_f", int'(stall_f), int'(st));
      cmp("m_issue_f", int'(issue_f), int'(is));
      cmp("m_fwda_f", int'(fa_f), fa);
      cmp("m_fwdb_f", int'(fb_f), fb);
      cmp("m_cnt_f", int'(cnt_f), mcnt[0]);
      model_eval(1, st, is, fa, fb);
      cmp("m_stall_i", int'(stall_i), int'(st));
      cmp("m_issue_i", int'(issue_i), int'(is));
      cmp("m_fwda_i", int'(fa_i), fa);
      cmp("m_fwdb_i", int'(fb_i), fb);
      cmp("m_cnt_i", int'(cnt_i), mcnt[1]);
    end
  end

  // Advance one cycle, then present a new ID vector and wait for the sample point.
  task automatic step(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                      input int rd, input bit wr, input bit ld, input bit fl, input bit hl,
                      input bit rst);
    @(posedge clk);
    model_update();
    chk_en = 1'b1;
    #1;
    id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
    id_rd = 5'(rd); id_wr = wr; id_load = ld; flush = fl; halted = hl; reset = rst;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state: empty scoreboard, issue follows id_valid.
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    cmp("rst_stall", int'(stall_f), 0);
    cmp("rst_issue", int'(issue_f), 1);
    cmp("rst_cnt", int'(cnt_f), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("rst_fwda", int'(fa_f), 0);

    // ADDI R8,R0,200 ; LW R9,0(R8)
    step(1, 0, 1, 0, 0, 8, 1, 0, 0, 0, 0);
    step(1, 8, 1, 0, 0, 9, 1, 1, 0, 0, 0);
    cmp("t1_stall_f", int'(stall_f), 0);
    cmp("t1_fwda_f", int'(fa_f), 1);
    cmp("t1_stall_i", int'(stall_i), 1);

    // MUL R10,R10,R9 after the load: one bubble, then forward from MEM
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t2_stall_f", int'(stall_f), 1);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t2_stall2_f", int'(stall_f), 0);
    cmp("t2_issue_f", int'(issue_f), 1);
    cmp("t2_fwdb_f", int'(fb_f), 2);
    cmp("t2_cnt_f", int'(cnt_f), 1);
    drain();

    // Interlock only: ADDI R10,R0,1 ; MUL R10,R10,R9 stalls two cycles
    step(1, 0, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t3_stall1_i", int'(stall_i), 1);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t3_stall2_i", int'(stall_i), 1);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t3_stall3_i", int'(stall_i), 0);
    cmp("t3_issue_i", int'(issue_i), 1);
    cmp("t3_fwda_i", int'(fa_i), 0);
    cmp("t3_cnt_i", int'(cnt_i), 4);
    drain();

    // R0 writer is never tracked; two R9 writers -> youngest wins
    step(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0);
    cmp("t4_r0_stall_f", int'(stall_f), 0);
    cmp("t4_r0_stall_i", int'(stall_i), 0);
    step(1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    step(1, 9, 1, 9, 1, 12, 1, 0, 0, 0, 0);
    cmp("t4_fwda_f", int'(fa_f), 1);
    cmp("t4_fwdb_f", int'(fb_f), 1);
    cmp("t4_stall_i", int'(stall_i), 1);
    drain();

    // BNEQZ R5 ; SUBI R9 (wrong path) ; flush with R9 consumer in ID
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    step(1, 9, 1, 9, 1, 11, 1, 0, 1, 0, 0);
    cmp("t5_fl_stall_i", int'(stall_i), 0);
    cmp("t5_fl_issue_f", int'(issue_f), 0);
    step(1, 9, 1, 9, 1, 11, 1, 0, 0, 0, 0);
    cmp("t5_issue_f", int'(issue_f), 1);
    cmp("t5_fwda_f", int'(fa_f), 0);
    cmp("t5_stall_i", int'(stall_i), 0);
    drain();

    // Reset asserted during a load-use stall
    step(1, 0, 1, 0, 0, 9, 1, 1, 0, 0, 0);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 1);
    cmp("t6_stall_f", int'(stall_f), 1);
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 0, 0);
    cmp("t6_stall_after_f", int'(stall_f), 0);
    cmp("t6_cnt_f", int'(cnt_f), 0);
    cmp("t6_cnt_i", int'(cnt_i), 0);
    cmp("t6_fwdb_f", int'(fb_f), 0);

    // Halted: consumer of the just-issued R10 neither stalls nor issues
    step(1, 10, 1, 9, 1, 10, 1, 0, 0, 1, 0);
    cmp("halt_stall_i", int'(stall_i), 0);
    cmp("halt_issue_f", int'(issue_f), 0);
    drain();

    @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
